// File: rtl/n64_pkg.sv
// Shared definitions for the N64 one-wire controller link (transmitter and receiver).
package n64_pkg;

  // Console command codes
  localparam logic [7:0] CMD_STATUS    = 8'h00;
  localparam logic [7:0] CMD_POLL      = 8'h01;
  localparam logic [7:0] CMD_PAK_READ  = 8'h02;
  localparam logic [7:0] CMD_PAK_WRITE = 8'h03;

  // Phase lengths in microseconds
  localparam int unsigned MUL_LOW0      = 3;
  localparam int unsigned MUL_LOW1      = 1;
  localparam int unsigned MUL_BIT       = 4;
  localparam int unsigned MUL_STOP_LOW  = 1;
  localparam int unsigned MUL_STOP_HIGH = 2;

  // Write controller states
  typedef enum logic [2:0] {
    WR_IDLE,
    WR_BIT_LOW,
    WR_BIT_HIGH,
    WR_STOP_LOW,
    WR_STOP_HIGH,
    WR_DONE
  } wr_state_e;

  // Phase length in clock cycles
  function automatic int unsigned phase_cycles(input int unsigned mult, input int unsigned clks);
    return mult * clks;
  endfunction

endpackage

// File: rtl/n64_phase_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module n64_phase_timer #(
  parameter  int unsigned CLKS_PER_US = 100,
  localparam int unsigned CW          = $clog2(3 * CLKS_PER_US)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/n64_write_controller.sv
// Console-side N64 command transmitter: serialises 1-3 bytes MSB-first plus stop bit.
module n64_write_controller
  import n64_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] cmd_data,
  input  logic [1:0]  cmd_len,
  input  logic        gpio_line,
  output logic        line_oe,
  output logic        busy,
  output logic        done,
  output logic        start_err
);

  localparam int unsigned CW = $clog2(3 * CLKS_PER_US);

  // Timer reload values (length - 1) for each phase
  localparam logic [CW-1:0] LD_LOW0      = CW'(phase_cycles(MUL_LOW0, CLKS_PER_US) - 1);
  localparam logic [CW-1:0] LD_LOW1      = CW'(phase_cycles(MUL_LOW1, CLKS_PER_US) - 1);
  localparam logic [CW-1:0] LD_HIGH0     = CW'(phase_cycles(MUL_BIT - MUL_LOW0, CLKS_PER_US) - 1);
  localparam logic [CW-1:0] LD_HIGH1     = CW'(phase_cycles(MUL_BIT - MUL_LOW1, CLKS_PER_US) - 1);
  localparam logic [CW-1:0] LD_STOP_LOW  = CW'(phase_cycles(MUL_STOP_LOW, CLKS_PER_US) - 1);
  localparam logic [CW-1:0] LD_STOP_HIGH = CW'(phase_cycles(MUL_STOP_HIGH, CLKS_PER_US) - 1);

  wr_state_e     state_q, state_d;
  logic [23:0]   shreg_q, shreg_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    last_q, last_d;
  logic          line_oe_q, line_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_err_q, start_err_d;
  logic [1:0]    len_eff;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_tc;

  n64_phase_timer #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  assign len_eff = (cmd_len == 2'd0) ? 2'd1 : cmd_len;

  // Next-state, datapath and registered-output decode.
  // Outputs are computed from state_d so they are valid in the same cycle the state is entered.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    last_d      = last_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    start_err_d = 1'b0;

    unique case (state_q)
      WR_IDLE: begin
        if (start) begin
          if (gpio_line) begin
            shreg_d  = cmd_data;
            last_d   = {len_eff - 2'd1, 3'b111};
            idx_d    = '0;
            state_d  = WR_BIT_LOW;
            tmr_load = 1'b1;
            tmr_val  = cmd_data[23] ? LD_LOW1 : LD_LOW0;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      WR_BIT_LOW: begin
        if (tmr_tc) begin
          state_d  = WR_BIT_HIGH;
          tmr_load = 1'b1;
          tmr_val  = shreg_q[23] ? LD_HIGH1 : LD_HIGH0;
        end
      end
      WR_BIT_HIGH: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (idx_q == last_q) begin
            state_d = WR_STOP_LOW;
            tmr_val = LD_STOP_LOW;
          end else begin
            idx_d   = idx_q + 5'd1;
            shreg_d = {shreg_q[22:0], 1'b0};
            state_d = WR_BIT_LOW;
            tmr_val = shreg_q[22] ? LD_LOW1 : LD_LOW0;
          end
        end
      end
      WR_STOP_LOW: begin
        if (tmr_tc) begin
          state_d  = WR_STOP_HIGH;
          tmr_load = 1'b1;
          tmr_val  = LD_STOP_HIGH;
        end
      end
      WR_STOP_HIGH: begin
        if (tmr_tc) begin
          state_d = WR_DONE;
        end
      end
      WR_DONE: begin
        state_d = WR_IDLE;
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase

    line_oe_d = (state_d == WR_BIT_LOW) || (state_d == WR_STOP_LOW);
    busy_d    = (state_d != WR_IDLE) && (state_d != WR_DONE);
    done_d    = (state_d == WR_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WR_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      line_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      line_oe_q   <= line_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
    end
  end

  assign line_oe   = line_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign start_err = start_err_q;

endmodule
